// File: rtl/cache_arbiter_pkg.sv
// Shared types and default widths for the cache arbiter.
package cache_arbiter_pkg;

  localparam int unsigned LINE_W_DEF = 256;
  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/cache_arbiter_if.sv
// Client (icache/dcache) and physical-memory port signals of the arbiter.
interface cache_arbiter_if #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
) ();

  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  // Arbiter side.
  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );

  // Caches plus memory side.
  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );

endinterface

// File: rtl/cache_arbiter_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         i_clr_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Count up on i_inc, stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!i_clr_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/cache_arbiter.sv
// Grants the single pmem port to the icache or dcache miss path, one at a time.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int unsigned LINE_W = LINE_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  cache_arbiter_if.slave   bus,
  output logic [CNT_W-1:0] i_svc_cnt,
  output logic [CNT_W-1:0] d_svc_cnt,
  output logic [CNT_W-1:0] busy_cnt
);

  arb_state_t        r_state;
  grant_t            r_last_grant;
  logic              r_pmem_read;
  logic              r_pmem_write;
  logic [ADDR_W-1:0] r_pmem_addr;
  logic [LINE_W-1:0] r_pmem_wdata;

  logic w_d_pend;
  logic w_grant_d;
  logic w_i_resp;
  logic w_d_resp;
  logic w_busy;

  // D wins a tie unless it was served last; this gives strict alternation.
  assign w_d_pend  = bus.d_read | bus.d_write;
  assign w_grant_d = w_d_pend & (~bus.i_read | (r_last_grant == GRANT_I));

  // Grant on IDLE, latch the winner's request, release on pmem_resp.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_last_grant <= GRANT_I;
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
      r_pmem_addr  <= '0;
      r_pmem_wdata <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state      <= SERVE_D;
            r_last_grant <= GRANT_D;
            r_pmem_addr  <= bus.d_addr;
            r_pmem_write <= bus.d_write;
            r_pmem_read  <= ~bus.d_write;
            r_pmem_wdata <= bus.d_write ? bus.d_wdata : LINE_W'(0);
          end else if (bus.i_read) begin
            r_state      <= SERVE_I;
            r_last_grant <= GRANT_I;
            r_pmem_addr  <= bus.i_addr;
            r_pmem_write <= 1'b0;
            r_pmem_read  <= 1'b1;
            r_pmem_wdata <= '0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (bus.pmem_resp) begin
            r_state      <= IDLE;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_pmem_read  <= 1'b0;
          r_pmem_write <= 1'b0;
        end
      endcase
    end
  end

  // Response path is combinational so the client sees completion in cycle R.
  assign w_i_resp = (r_state == SERVE_I) & bus.pmem_resp;
  assign w_d_resp = (r_state == SERVE_D) & bus.pmem_resp;
  assign w_busy   = (r_state != IDLE);

  assign bus.i_resp     = w_i_resp;
  assign bus.d_resp     = w_d_resp;
  assign bus.i_rdata    = bus.pmem_rdata;
  assign bus.d_rdata    = bus.pmem_rdata;
  assign bus.pmem_read  = r_pmem_read;
  assign bus.pmem_write = r_pmem_write;
  assign bus.pmem_addr  = r_pmem_addr;
  assign bus.pmem_wdata = r_pmem_wdata;

  sat_counter #(.W(CNT_W)) u_i_svc (
    .clk     (clk),
    .i_clr_n (rst),
    .i_inc   (w_i_resp),
    .o_cnt   (i_svc_cnt)
  );

  sat_counter #(.W(CNT_W)) u_d_svc (
    .clk     (clk),
    .i_clr_n (rst),
    .i_inc   (w_d_resp),
    .o_cnt   (d_svc_cnt)
  );

  sat_counter #(.W(CNT_W)) u_busy (
    .clk     (clk),
    .i_clr_n (rst),
    .i_inc   (w_busy),
    .o_cnt   (busy_cnt)
  );

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-level model; a 4-bit-counter copy shadows the same traffic.
module tb_cache_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cache_arbiter_if #(.LINE_W(256), .ADDR_W(32)) bus ();
  cache_arbiter_if #(.LINE_W(256), .ADDR_W(32)) bus4 ();

  logic [31:0] i_cnt, d_cnt, b_cnt;
  logic [3:0]  i_cnt4, d_cnt4, b_cnt4;

  cache_arbiter #(.LINE_W(256), .ADDR_W(32), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .bus(bus),
    .i_svc_cnt(i_cnt), .d_svc_cnt(d_cnt), .busy_cnt(b_cnt)
  );

  cache_arbiter #(.LINE_W(256), .ADDR_W(32), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .bus(bus4),
    .i_svc_cnt(i_cnt4), .d_svc_cnt(d_cnt4), .busy_cnt(b_cnt4)
  );

  // The narrow-counter copy sees exactly the same client and memory traffic.
  assign bus4.i_read     = bus.i_read;
  assign bus4.i_addr     = bus.i_addr;
  assign bus4.d_read     = bus.d_read;
  assign bus4.d_write    = bus.d_write;
  assign bus4.d_addr     = bus.d_addr;
  assign bus4.d_wdata    = bus.d_wdata;
  assign bus4.pmem_rdata = bus.pmem_rdata;
  assign bus4.pmem_resp  = bus.pmem_resp;

  int checks = 0;
  int errors = 0;

  // Model state: pending requests and expected counts.
  bit           m_last_d;
  int           m_isvc, m_dsvc, m_busy;
  bit           p_i, p_d, p_w;
  logic [31:0]  a_i, a_d;
  logic [255:0] w_d;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int sat4(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.i_read  = p_i;
    bus.i_addr  = a_i;
    bus.d_read  = p_d & ~p_w;
    bus.d_write = p_d & p_w;
    bus.d_addr  = a_d;
    bus.d_wdata = w_d;
  endtask

  task automatic check_cnt(input string tag);
    check({tag, "_isvc"},  256'(i_cnt),  256'(m_isvc));
    check({tag, "_dsvc"},  256'(d_cnt),  256'(m_dsvc));
    check({tag, "_busy"},  256'(b_cnt),  256'(m_busy));
    check({tag, "_isvc4"}, 256'(i_cnt4), 256'(sat4(m_isvc)));
    check({tag, "_dsvc4"}, 256'(d_cnt4), 256'(sat4(m_dsvc)));
    check({tag, "_busy4"}, 256'(b_cnt4), 256'(sat4(m_busy)));
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_rd"},    256'(bus.pmem_read),  256'(0));
    check({tag, "_wr"},    256'(bus.pmem_write), 256'(0));
    check({tag, "_iresp"}, 256'(bus.i_resp),     256'(0));
    check({tag, "_dresp"}, 256'(bus.d_resp),     256'(0));
  endtask

  // Called at a negedge with at least one request pending; runs one full
  // transaction with memory latency lat and returns at the negedge of R+1.
  task automatic serve(input string tag, input int lat);
    bit           win_d, exp_w;
    logic [31:0]  exp_addr;
    logic [255:0] exp_wd, rd;
    check({tag, "_rw_legal"}, 256'(bus.d_read & bus.d_write), 256'(0));
    win_d    = p_d && (!p_i || !m_last_d);
    exp_w    = win_d && p_w;
    exp_addr = win_d ? a_d : a_i;
    exp_wd   = exp_w ? w_d : '0;
    @(posedge clk); #1;
    m_last_d = win_d;
    check({tag, "_grant_rd"},   256'(bus.pmem_read),  256'(!exp_w));
    check({tag, "_grant_wr"},   256'(bus.pmem_write), 256'(exp_w));
    check({tag, "_grant_addr"}, 256'(bus.pmem_addr),  256'(exp_addr));
    check({tag, "_grant_wd"},   bus.pmem_wdata,       exp_wd);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      a_i = $urandom;
      a_d = $urandom;
      w_d = rand256();
      drive();
      rd = rand256();
      bus.pmem_rdata = rd;
      bus.pmem_resp  = (k == lat);
      #1;
      check({tag, "_hold_addr"}, 256'(bus.pmem_addr), 256'(exp_addr));
      check({tag, "_hold_wd"},   bus.pmem_wdata,      exp_wd);
      check({tag, "_hold_rd"},   256'(bus.pmem_read), 256'(!exp_w));
      check({tag, "_iresp"}, 256'(bus.i_resp), 256'((k == lat) && !win_d));
      check({tag, "_dresp"}, 256'(bus.d_resp), 256'((k == lat) && win_d));
      if (k == lat) check({tag, "_rdata"}, win_d ? bus.d_rdata : bus.i_rdata, rd);
      @(posedge clk);
      m_busy++;
      if (k == lat) begin
        if (win_d) m_dsvc++; else m_isvc++;
      end
    end
    #1;
    check({tag, "_done_rd"}, 256'(bus.pmem_read),  256'(0));
    check({tag, "_done_wr"}, 256'(bus.pmem_write), 256'(0));
    check_cnt(tag);
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    if (win_d) p_d = 1'b0; else p_i = 1'b0;
    drive();
  endtask

  // Idle cycles with no requests; stray pmem_resp must be ignored.
  task automatic idle(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.pmem_resp  = 1'($urandom_range(0, 1));
      bus.pmem_rdata = rand256();
      #1;
      check_idle_outs(tag);
      @(posedge clk);
    end
    #1;
    check_cnt(tag);
    @(negedge clk);
    bus.pmem_resp = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    p_i = 1'b0; p_d = 1'b0; p_w = 1'b0;
    drive();
    bus.pmem_resp = 1'b0;
    @(posedge clk); #1;
    m_last_d = 1'b0;
    m_isvc = 0; m_dsvc = 0; m_busy = 0;
    check_idle_outs(tag);
    check({tag, "_addr"}, 256'(bus.pmem_addr), 256'(0));
    check({tag, "_wd"},   bus.pmem_wdata,      256'(0));
    check_cnt(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    a_i = '0; a_d = '0; w_d = '0;
    p_i = 1'b0; p_d = 1'b0; p_w = 1'b0;
    drive();
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;

    do_reset("reset");
    idle("idle0", 2);

    // Lone icache miss, memory latency 5.
    p_i = 1'b1; a_i = 32'h0000_0040;
    drive();
    begin
      logic [255:0] a5;
      a5 = {32{8'hA5}};
      @(posedge clk); #1;
      check("lone_grant_rd",   256'(bus.pmem_read), 256'(1));
      check("lone_grant_addr", 256'(bus.pmem_addr), 256'(32'h40));
      for (int k = 1; k <= 5; k++) begin
        @(negedge clk);
        bus.pmem_resp  = (k == 5);
        bus.pmem_rdata = a5;
        #1;
        check("lone_iresp", 256'(bus.i_resp), 256'(k == 5));
        @(posedge clk);
      end
      #1;
      check("lone_rdone", 256'(bus.pmem_read), 256'(0));
      check("lone_isvc",  256'(i_cnt), 256'(1));
      check("lone_busy",  256'(b_cnt), 256'(5));
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      p_i = 1'b0;
      drive();
      m_isvc = 1; m_busy = 5; m_last_d = 1'b0;
    end
    idle("idle1", 1);

    // Simultaneous requests after reset: D first, then I.
    do_reset("reset2");
    p_i = 1'b1; a_i = 32'h0000_0080;
    p_d = 1'b1; p_w = 1'b0; a_d = 32'h0000_0100;
    drive();
    serve("sim_d", 3);
    check("sim_first_d", 256'(d_cnt), 256'(1));
    check("sim_first_i", 256'(i_cnt), 256'(0));
    serve("sim_i", 2);
    check("sim_second_i", 256'(i_cnt), 256'(1));

    // Continuous contention over six transactions.
    do_reset("reset3");
    p_i = 1'b1; p_d = 1'b1; p_w = 1'b0;
    drive();
    for (int n = 0; n < 6; n++) begin
      serve("cont", $urandom_range(1, 3));
      p_i = 1'b1; p_d = 1'b1;
      drive();
    end
    p_i = 1'b0; p_d = 1'b0;
    drive();
    check("cont_dsvc", 256'(d_cnt), 256'(3));
    check("cont_isvc", 256'(i_cnt), 256'(3));

    // Writeback.
    p_d = 1'b1; p_w = 1'b1; a_d = 32'h0000_0200; w_d = {16{16'hDEAD}};
    drive();
    serve("wb", 4);
    p_w = 1'b0;
    drive();
    idle("idle2", 3);

    // Reset two cycles into SERVE_I; a late pmem_resp must be ignored.
    p_i = 1'b1; a_i = 32'h0000_0300;
    drive();
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    p_i = 1'b0;
    drive();
    @(posedge clk); #1;
    m_last_d = 1'b0;
    m_isvc = 0; m_dsvc = 0; m_busy = 0;
    check_idle_outs("midrst");
    check_cnt("midrst");
    @(negedge clk);
    rst = 1'b1;
    bus.pmem_resp = 1'b1;
    #1;
    check("midrst_late_iresp", 256'(bus.i_resp), 256'(0));
    @(posedge clk); #1;
    check_idle_outs("midrst_after");
    check_cnt("midrst_after");
    @(negedge clk);
    bus.pmem_resp = 1'b0;

    // Random traffic; long enough for the 4-bit counters to saturate.
    do_reset("reset4");
    for (int n = 0; n < 40; n++) begin
      if (!p_i && ($urandom_range(0, 1) == 1)) begin
        p_i = 1'b1; a_i = $urandom;
      end
      if (!p_d && ($urandom_range(0, 1) == 1)) begin
        p_d = 1'b1; p_w = 1'($urandom_range(0, 1)); a_d = $urandom; w_d = rand256();
      end
      if (!p_i && !p_d) begin
        p_i = 1'b1; a_i = $urandom;
      end
      drive();
      serve("rand", $urandom_range(1, 4));
    end
    p_i = 1'b0; p_d = 1'b0;
    drive();
    idle("idle3", 2);
    check("sat_busy4", 256'(b_cnt4), 256'(15));
    check("sat_total", 256'(i_cnt + d_cnt), 256'(40));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
